// File: rtl/axi_pkg.sv
// Shared AXI4 encodings: response codes, burst types and the single supported beat size.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  // Only 32-bit INCR bursts are serviced without error.
  function automatic logic is_word_incr(input logic [2:0] size, input logic [1:0] burst);
    return (size == AXI_SIZE_4B) && (burst == AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module sram_1rw #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Contents are intentionally never reset so data survives a bus reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < DW/8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_data_memory.sv
// AXI4 slave word memory: one transaction at a time, INCR word bursts,
// SLVERR for out-of-range beats, unsupported size/burst or wlast mismatch.
module axi_data_memory
  import axi_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned MEM_DEPTH_WORDS    = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          mem_is_busy
);

  localparam int unsigned ID_W   = C_S_AXI_ID_WIDTH;
  localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
  // One spare bit so a burst running past the top never wraps back to word 0.
  localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 1;
  localparam int unsigned RAM_AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE_DATA, ST_WRITE_RESP, ST_READ_FETCH, ST_READ_DATA
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [8:0]          beats_q, beats_d;
  logic                err_q, err_d;
  logic                awready_q, awready_d, arready_q, arready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                busy_q, busy_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [ID_W-1:0]     bid_q, bid_d, rid_q, rid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                aw_hs_c, ar_hs_c, w_hs_c, b_hs_c, r_hs_c;
  logic                in_range_c, last_beat_c;
  logic                ram_en_c, ram_we_c;
  logic [IDX_W-1:0]    ram_idx_c;
  logic [DATA_W-1:0]   ram_rdata;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Write has priority: a simultaneous AR is simply not acknowledged.
  assign aw_hs_c     = s_axi_awvalid & awready_q;
  assign ar_hs_c     = s_axi_arvalid & arready_q & ~s_axi_awvalid;
  assign w_hs_c      = s_axi_wvalid & wready_q;
  assign b_hs_c      = s_axi_bready & bvalid_q;
  assign r_hs_c      = s_axi_rready & rvalid_q;
  assign in_range_c  = idx_q < IDX_W'(MEM_DEPTH_WORDS);
  assign last_beat_c = beats_q == 9'd1;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    idx_d     = idx_q;
    beats_d   = beats_q;
    err_d     = err_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    ram_en_c  = 1'b0;
    ram_we_c  = 1'b0;
    ram_idx_c = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (aw_hs_c) begin
          id_d    = s_axi_awid;
          idx_d   = {1'b0, s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2]};
          beats_d = 9'(s_axi_awlen) + 9'd1;
          err_d   = ~is_word_incr(s_axi_awsize, s_axi_awburst);
          state_d = ST_WRITE_DATA;
        end else if (ar_hs_c) begin
          id_d      = s_axi_arid;
          idx_d     = {1'b0, s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]};
          beats_d   = 9'(s_axi_arlen) + 9'd1;
          err_d     = ~is_word_incr(s_axi_arsize, s_axi_arburst);
          ram_en_c  = 1'b1;
          ram_idx_c = idx_d;
          state_d   = ST_READ_FETCH;
        end
      end
      ST_WRITE_DATA: begin
        if (w_hs_c) begin
          if (in_range_c) begin
            ram_en_c = 1'b1;
            ram_we_c = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (s_axi_wlast != last_beat_c) err_d = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          beats_d = beats_q - 9'd1;
          if (last_beat_c) begin
            bresp_d = err_d ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            bid_d   = id_q;
            state_d = ST_WRITE_RESP;
          end
        end
      end
      ST_WRITE_RESP: begin
        if (b_hs_c) state_d = ST_IDLE;
      end
      ST_READ_FETCH: begin
        rid_d   = id_q;
        rdata_d = in_range_c ? ram_rdata : '0;
        rresp_d = (err_q || !in_range_c) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rlast_d = last_beat_c;
        state_d = ST_READ_DATA;
      end
      ST_READ_DATA: begin
        if (r_hs_c) begin
          rlast_d = 1'b0;
          if (last_beat_c) begin
            state_d = ST_IDLE;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            beats_d   = beats_q - 9'd1;
            ram_en_c  = 1'b1;
            ram_idx_c = idx_d;
            state_d   = ST_READ_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    awready_d = state_d == ST_IDLE;
    arready_d = state_d == ST_IDLE;
    wready_d  = state_d == ST_WRITE_DATA;
    bvalid_d  = state_d == ST_WRITE_RESP;
    rvalid_d  = state_d == ST_READ_DATA;
    busy_d    = state_d != ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      idx_q     <= '0;
      beats_q   <= '0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      bid_q     <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      beats_q   <= beats_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      busy_q    <= busy_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      bid_q     <= bid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  sram_1rw #(
    .DEPTH (MEM_DEPTH_WORDS),
    .DW    (DATA_W),
    .AW    (RAM_AW)
  ) u_sram (
    .clk   (clk),
    .en    (ram_en_c),
    .we    (ram_we_c),
    .be    (s_axi_wstrb),
    .addr  (RAM_AW'(ram_idx_c)),
    .wdata (s_axi_wdata),
    .rdata (ram_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_arready = arready_q & ~s_axi_awvalid;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign mem_is_busy   = busy_q;

endmodule

// File: tb/tb_axi_data_memory.sv
// Bench for axi_data_memory: directed vector table, hand-written corner sequences
// and randomized bursts checked against an array-based memory model.
module tb_axi_data_memory;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned IDW   = 1;

  logic            clk, reset;
  logic [IDW-1:0]  awid, arid, bid, rid;
  logic [31:0]     awaddr, araddr, wdata, rdata;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic [3:0]      wstrb;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready, busy;

  axi_data_memory #(
    .C_S_AXI_ADDR_WIDTH (32),
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ID_WIDTH   (IDW),
    .MEM_DEPTH_WORDS    (DEPTH)
  ) dut (
    .clk (clk), .reset (reset),
    .s_axi_awid (awid), .s_axi_awaddr (awaddr), .s_axi_awlen (awlen),
    .s_axi_awsize (awsize), .s_axi_awburst (awburst),
    .s_axi_awvalid (awvalid), .s_axi_awready (awready),
    .s_axi_wdata (wdata), .s_axi_wstrb (wstrb), .s_axi_wlast (wlast),
    .s_axi_wvalid (wvalid), .s_axi_wready (wready),
    .s_axi_bid (bid), .s_axi_bresp (bresp), .s_axi_bvalid (bvalid), .s_axi_bready (bready),
    .s_axi_arid (arid), .s_axi_araddr (araddr), .s_axi_arlen (arlen),
    .s_axi_arsize (arsize), .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid), .s_axi_arready (arready),
    .s_axi_rid (rid), .s_axi_rdata (rdata), .s_axi_rresp (rresp), .s_axi_rlast (rlast),
    .s_axi_rvalid (rvalid), .s_axi_rready (rready),
    .mem_is_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int w_gap_pct = 0;
  int b_delay_max = 0;

  logic [31:0] wbuf  [256];
  logic [3:0]  sbuf  [256];
  logic        lbuf  [256];
  logic [31:0] rdbuf [256];
  logic [1:0]  rrbuf [256];
  logic        rlbuf [256];

  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_ok  [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout actual=no-handshake required=handshake", name);
  endtask

  // Reference model: words live in a plain array, error per AXI rules.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input logic [2:0] size, input logic [1:0] burst);
    bit err;
    longint unsigned idx;
    err = !(size == 3'd2 && burst == 2'b01);
    for (int b = 0; b <= len; b++) begin
      idx = 64'(addr[31:2]) + 64'(b);
      if (lbuf[b] != (b == len)) err = 1;
      if (idx < DEPTH) begin
        for (int k = 0; k < 4; k++)
          if (sbuf[b][k]) mdl_mem[int'(idx)][8*k +: 8] = wbuf[b][8*k +: 8];
        if (sbuf[b] == 4'hF) mdl_ok[int'(idx)] = 1;
      end else begin
        err = 1;
      end
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic check_read(input string name, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
    bit bad;
    longint unsigned idx;
    bad = !(size == 3'd2 && burst == 2'b01);
    for (int b = 0; b <= len; b++) begin
      idx = 64'(addr[31:2]) + 64'(b);
      chk({name, "_rresp"}, 64'(rrbuf[b]), 64'((bad || idx >= DEPTH) ? 2'b10 : 2'b00));
      chk({name, "_rlast"}, 64'(rlbuf[b]), 64'(b == len));
      if (idx >= DEPTH) chk({name, "_rdata_oor"}, 64'(rdbuf[b]), 64'(0));
      else if (mdl_ok[int'(idx)]) chk({name, "_rdata"}, 64'(rdbuf[b]), 64'(mdl_mem[int'(idx)]));
    end
  endtask

  task automatic axi_write(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           output logic [1:0] resp);
    int guard;
    int dly;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
    awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) timeout("aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (int'($urandom_range(0, 99)) < w_gap_pct) begin
        wvalid = 1'b0;
        @(posedge clk); #1;
      end
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wlast = lbuf[b];
      guard = 0;
      while (!wready && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) timeout("w");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_latency", 64'(bvalid), 64'(1));
    chk("bid", 64'(bid), 64'(id));
    dly = int'($urandom_range(0, b_delay_max));
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 64'(bvalid), 64'(1));
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_drop", 64'(bvalid), 64'(0));
  endtask

  // stall_mode: 0 no stalls, 1 one stall cycle per beat, 2 random 0..2 stall cycles.
  task automatic axi_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_mode);
    int guard;
    int stalls;
    logic [35:0] snap;
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
    arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) timeout("ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_fetch_cycle", 64'(rvalid), 64'(0));
    for (int b = 0; b <= len; b++) begin
      @(posedge clk); #1;
      chk("rvalid_latency", 64'(rvalid), 64'(1));
      chk("rid", 64'(rid), 64'(id));
      snap = {rvalid, rlast, rresp, rdata};
      stalls = (stall_mode == 1) ? 1 : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < stalls; s++) begin
        rready = 1'b0;
        @(posedge clk); #1;
        chk("r_hold_stable", 64'({rvalid, rlast, rresp, rdata}), 64'(snap));
      end
      rdbuf[b] = rdata; rrbuf[b] = rresp; rlbuf[b] = rlast;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      chk("rvalid_after_accept", 64'(rvalid), 64'(0));
    end
    chk("busy_after_read", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t        vecs [8];
  logic [1:0]  got_b;
  logic [1:0]  exp_b;
  logic [31:0] raddr;
  int          rlen;
  logic [2:0]  rsize;
  logic [1:0]  rburst;

  initial begin
    vecs[0] = '{32'h040, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{32'h044, 3'd2, 2'b01, 32'h11223344, 4'hF, 2'b00, 32'h11223344, 2'b00};
    vecs[2] = '{32'h044, 3'd2, 2'b01, 32'hAABBCCDD, 4'h5, 2'b00, 32'h11BB33DD, 2'b00};
    vecs[3] = '{32'h048, 3'd1, 2'b01, 32'h55AA55AA, 4'hF, 2'b10, 32'h55AA55AA, 2'b10};
    vecs[4] = '{32'h04C, 3'd2, 2'b00, 32'h01020304, 4'hF, 2'b10, 32'h01020304, 2'b10};
    vecs[5] = '{32'h400, 3'd2, 2'b01, 32'h99999999, 4'hF, 2'b10, 32'h00000000, 2'b10};
    vecs[6] = '{32'h3FC, 3'd2, 2'b01, 32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D, 2'b00};
    vecs[7] = '{32'h040, 3'd2, 2'b01, 32'h77777777, 4'h0, 2'b00, 32'hDEADBEEF, 2'b00};

    reset = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_awready", 64'(awready), 64'(0));
    chk("reset_arready", 64'(arready), 64'(0));
    chk("reset_outputs", 64'({bvalid, rvalid, rlast, wready, busy, bresp, rresp, rdata}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("awready_before_edge", 64'(awready), 64'(0));
    @(posedge clk); #1;
    chk("awready_after_release", 64'(awready), 64'(1));
    chk("arready_after_release", 64'(arready), 64'(1));

    // Single-beat directed vectors.
    foreach (vecs[i]) begin
      wbuf[0] = vecs[i].wdata; sbuf[0] = vecs[i].strb; lbuf[0] = 1'b1;
      void'(model_write(vecs[i].addr, 0, vecs[i].size, vecs[i].burst));
      axi_write(1'(i), vecs[i].addr, 0, vecs[i].size, vecs[i].burst, got_b);
      chk($sformatf("vec%0d_bresp", i), 64'(got_b), 64'(vecs[i].exp_bresp));
      axi_read(1'(i + 1), vecs[i].addr, 0, vecs[i].size, vecs[i].burst, 0);
      chk($sformatf("vec%0d_rdata", i), 64'(rdbuf[0]), 64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_rresp", i), 64'(rrbuf[0]), 64'(vecs[i].exp_rresp));
      chk($sformatf("vec%0d_rlast", i), 64'(rlbuf[0]), 64'(1));
    end

    // 4-beat burst, read back with rready toggling.
    for (int b = 0; b < 4; b++) begin wbuf[b] = 32'(b + 1); sbuf[b] = 4'hF; lbuf[b] = (b == 3); end
    void'(model_write(32'h100, 3, 3'd2, 2'b01));
    axi_write(1'b0, 32'h100, 3, 3'd2, 2'b01, got_b);
    chk("burst4_bresp", 64'(got_b), 64'(0));
    axi_read(1'b1, 32'h100, 3, 3'd2, 2'b01, 1);
    for (int b = 0; b < 4; b++) begin
      chk("burst4_rdata", 64'(rdbuf[b]), 64'(b + 1));
      chk("burst4_rlast", 64'(rlbuf[b]), 64'(b == 3));
    end

    // Same-cycle AW and AR: the write must win.
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF; lbuf[0] = 1'b1;
    void'(model_write(32'h80, 0, 3'd2, 2'b01));
    axi_write(1'b0, 32'h80, 0, 3'd2, 2'b01, got_b);
    awid = 1'b0; awaddr = 32'h80; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 1'b1; araddr = 32'h80; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("collide_awready", 64'(awready), 64'(1));
    chk("collide_arready", 64'(arready), 64'(0));
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("collide_busy", 64'(busy), 64'(1));
    chk("collide_arready_wr", 64'(arready), 64'(0));
    wvalid = 1'b1; wdata = 32'h87654321; wstrb = 4'hF; wlast = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    chk("collide_bvalid", 64'(bvalid), 64'(1));
    chk("collide_bresp", 64'(bresp), 64'(0));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(1'b1, 32'h80, 0, 3'd2, 2'b01, 0);
    chk("collide_rdata", 64'(rdbuf[0]), 64'h87654321);

    // Burst crossing the top of memory.
    wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    lbuf[0] = 1'b0; lbuf[1] = 1'b1;
    void'(model_write(32'h3FC, 1, 3'd2, 2'b01));
    axi_write(1'b1, 32'h3FC, 1, 3'd2, 2'b01, got_b);
    chk("cross_bresp", 64'(got_b), 64'(2));
    axi_read(1'b0, 32'h3FC, 1, 3'd2, 2'b01, 2);
    chk("cross_beat0_rdata", 64'(rdbuf[0]), 64'hA5A5A5A5);
    chk("cross_beat0_rresp", 64'(rrbuf[0]), 64'(0));
    chk("cross_beat1_rdata", 64'(rdbuf[1]), 64'(0));
    chk("cross_beat1_rresp", 64'(rrbuf[1]), 64'(2));

    // Early wlast on beat 1 of 3: all beats stored, SLVERR.
    for (int b = 0; b < 3; b++) begin wbuf[b] = 32'hC0DE0000 + 32'(b); sbuf[b] = 4'hF; lbuf[b] = (b == 1); end
    void'(model_write(32'h300, 2, 3'd2, 2'b01));
    axi_write(1'b0, 32'h300, 2, 3'd2, 2'b01, got_b);
    chk("early_wlast_bresp", 64'(got_b), 64'(2));
    axi_read(1'b0, 32'h300, 2, 3'd2, 2'b01, 0);
    check_read("early_wlast", 32'h300, 2, 3'd2, 2'b01);

    // Missing wlast on a 2-beat burst.
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; sbuf[0] = 4'hF; sbuf[1] = 4'hF; lbuf[0] = 1'b0; lbuf[1] = 1'b0;
    void'(model_write(32'h310, 1, 3'd2, 2'b01));
    axi_write(1'b0, 32'h310, 1, 3'd2, 2'b01, got_b);
    chk("missing_wlast_bresp", 64'(got_b), 64'(2));

    // Top-of-address-space burst must not wrap onto word 0.
    wbuf[0] = 32'h0; sbuf[0] = 4'hF; lbuf[0] = 1'b1;
    void'(model_write(32'h0, 0, 3'd2, 2'b01));
    axi_write(1'b0, 32'h0, 0, 3'd2, 2'b01, got_b);
    wbuf[0] = 32'hEEEEEEEE; wbuf[1] = 32'hFFFFFFFF; lbuf[0] = 1'b0; lbuf[1] = 1'b1; sbuf[1] = 4'hF;
    void'(model_write(32'hFFFFFFFC, 1, 3'd2, 2'b01));
    axi_write(1'b0, 32'hFFFFFFFC, 1, 3'd2, 2'b01, got_b);
    chk("nowrap_bresp", 64'(got_b), 64'(2));
    axi_read(1'b0, 32'h0, 0, 3'd2, 2'b01, 0);
    chk("nowrap_word0", 64'(rdbuf[0]), 64'(0));

    // Reset during the second beat of a 4-beat read.
    for (int b = 0; b < 4; b++) begin wbuf[b] = 32'hA0 + 32'(b); sbuf[b] = 4'hF; lbuf[b] = (b == 3); end
    void'(model_write(32'h180, 3, 3'd2, 2'b01));
    axi_write(1'b0, 32'h180, 3, 3'd2, 2'b01, got_b);
    arid = 1'b0; araddr = 32'h180; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(posedge clk); #1;
    chk("rst_beat1_rvalid", 64'(rvalid), 64'(1));
    chk("rst_beat1_rdata", 64'(rdata), 64'hA1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_rvalid", 64'(rvalid), 64'(0));
    chk("rst_async_busy", 64'(busy), 64'(0));
    chk("rst_async_outputs", 64'({awready, arready, rlast, rdata}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_awready", 64'(awready), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_release_no_comb", 64'(awready), 64'(0));
    @(posedge clk); #1;
    chk("rst_release_awready", 64'(awready), 64'(1));
    chk("rst_release_arready", 64'(arready), 64'(1));
    axi_read(1'b1, 32'h180, 3, 3'd2, 2'b01, 0);
    check_read("rst_intact", 32'h180, 3, 3'd2, 2'b01);

    // Randomized bursts against the model.
    w_gap_pct = 25;
    b_delay_max = 2;
    for (int t = 0; t < 40; t++) begin
      int unsigned widx;
      int len;
      logic [2:0] sz;
      logic [1:0] bt;
      widx = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 8, DEPTH + 2)
                                         : $urandom_range(0, DEPTH - 1);
      len = int'($urandom_range(0, 7));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      bt = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      for (int b = 0; b <= len; b++) begin
        wbuf[b] = $urandom;
        sbuf[b] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        lbuf[b] = ($urandom_range(0, 19) == 0) ? ~(b == len) : (b == len);
      end
      exp_b = model_write(32'(widx) << 2, len, sz, bt);
      axi_write(1'($urandom), 32'(widx) << 2, len, sz, bt, got_b);
      chk("rand_bresp", 64'(got_b), 64'(exp_b));
      raddr = 32'(widx) << 2;
      rlen = len;
      rsize = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'd2;
      rburst = 2'b01;
      axi_read(1'($urandom), raddr, rlen, rsize, rburst, 2);
      check_read("rand", raddr, rlen, rsize, rburst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
